pio_rmw_arbiter: RTL and testbench
==================================

PIO_RMW_ARBITER -- requirements
Module: pio_rmw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 32, PIO data width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester update request, level.
REQ-006 req_data  input  NUM_REQ*DATA_W  new bit values; requester i at slice [i*DATA_W +: DATA_W].
REQ-007 req_mask  input  NUM_REQ*DATA_W  bits to modify, 1 = take req_data bit; same slicing as req_data.
REQ-008 ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high while a transaction is in progress (any state except IDLE).
REQ-010 pio_address  output  2  PIO slave address; always 0.
REQ-011 pio_chipselect  output  1  PIO slave select.
REQ-012 pio_write_n  output  1  PIO write strobe, active-low.
REQ-013 pio_writedata  output  DATA_W  PIO write data.
REQ-014 pio_readdata  input  DATA_W  PIO read data; combinational from the slave, valid in the same cycle as the read access.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WRITE, ACK.
REQ-016 IDLE: if any req bit is high, the block SHALL select one winner, latch its index, req_data slice and req_mask slice, and go to READ; otherwise it SHALL stay in IDLE.
REQ-017 READ: chipselect=1, write_n=1, address=0; the block SHALL capture pio_readdata at the clock edge and go to WRITE.
REQ-018 WRITE: chipselect=1, write_n=0, address=0, writedata=(captured & ~mask) | (data & mask); then go to ACK.
REQ-019 ACK: ack[winner]=1 for exactly one cycle, round-robin pointer updated to (winner+1) mod NUM_REQ, then go to IDLE.
REQ-020 Outside READ/WRITE: chipselect=0, write_n=1, writedata=0.
REQ-021 Latency: a req seen in IDLE at cycle t SHALL produce ack at cycle t+3; at most one transaction per 4 cycles.
REQ-022 Arbitration is round-robin: the winner is the first high req at or after the pointer, wrapping from NUM_REQ-1 to 0.
REQ-023 Data and mask are latched at grant; later changes, or req deasserting before ack, SHALL NOT alter or abort the transaction.
REQ-024 An all-zero mask SHALL still perform the read and the write, writing back the unchanged value.
REQ-025 A requester that holds req high after its ack SHALL be rearbitrated in the next IDLE cycle as a fresh request.
REQ-026 No new request is accepted outside IDLE; pending req bits wait without loss.

Reset
REQ-027 When reset_n is asserted, the block SHALL enter IDLE with pointer=0, ack=0, busy=0, chipselect=0, write_n=1, address=0, writedata=0 and latched data/mask=0.
REQ-028 Reset during READ or WRITE SHALL abort the transaction with no further PIO access and no ack; if reset is asserted in the READ state, no write occurs.

Configuration
REQ-029 Macro PIO_RMW_FIXED_PRI_EN: when defined, arbitration is fixed-priority (lowest index wins) and the pointer is absent; when undefined, round-robin per REQ-022.

Structure
REQ-030 Package pio_rmw_pkg SHALL hold the state enum typedef and constant PIO_DATA_ADDR = 2'd0.
REQ-031 Sub-module pio_rr_arbiter SHALL hold the winner selection and pointer logic; the top holds the FSM and datapath.

Verification
REQ-032 Single request: PIO holds 0x0000_00FF; req[1] with data 0xAB00_0000, mask 0xFF00_0000 -> one read, then write 0xAB00_00FF; ack[1] pulses 3 cycles after req.
REQ-033 Contention: req[0]–req[3] all held high from reset -> acks in order 0,1,2,3,0…, each 4 cycles apart.
REQ-034 Fairness wrap: pointer at 3; req[3] and req[0] both high -> 3 is served first, then 0.
REQ-035 Mid-transaction change: req_data changes and req drops one cycle after grant -> write uses the latched values; ack still issued.
REQ-036 Reset in READ: assert reset_n low while in READ -> no write strobe, no ack, all outputs at reset values; next request served normally.
REQ-037 With PIO_RMW_FIXED_PRI_EN defined, req[0] and req[2] held high continuously -> only requester 0 is ever acked.

Source files
------------

// File: rtl/pio_rmw_pkg.sv
// Shared types and constants for the PIO read-modify-write arbiter.
// Optional feature macro: PIO_RMW_FIXED_PRI_EN (fixed-priority arbitration).
package pio_rmw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/pio_rr_arbiter.sv
// Winner selection for the PIO RMW arbiter: round-robin with a rotating pointer,
// or fixed lowest-index priority when PIO_RMW_FIXED_PRI_EN is defined.
module pio_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
`ifndef PIO_RMW_FIXED_PRI_EN
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_advance,
    input  logic [IDX_W-1:0]   i_last,
`endif
    input  logic [NUM_REQ-1:0] i_req,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

`ifdef PIO_RMW_FIXED_PRI_EN

    // Scanning downward lets the lowest index overwrite any higher candidate.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end

`else

    logic [IDX_W-1:0] r_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (i_last == IDX_W'(NUM_REQ - 1)) ? '0 : i_last + 1'b1;
        end
    end

    // NOTE: every output gets a default before the loop, otherwise paths that
    // find no request would infer latches.
    always_comb begin
        int j;
        o_valid = 1'b0;
        o_idx   = '0;
        j       = 0;
        // Smallest offset from the pointer is assigned last and therefore wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
            end
        end
    end

`endif

endmodule

// File: rtl/pio_rmw_arbiter.sv
// Arbitrates several requesters for read-modify-write updates of one PIO register.
// Define PIO_RMW_FIXED_PRI_EN for fixed-priority instead of round-robin arbitration.
module pio_rmw_arbiter
    import pio_rmw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_mask,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [1:0]                pio_address,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [DATA_W-1:0]         pio_writedata,
    input  logic [DATA_W-1:0]         pio_readdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_winner;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_mask;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_grant_valid;
    logic [IDX_W-1:0]    w_grant_idx;

    pio_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
`ifndef PIO_RMW_FIXED_PRI_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .i_advance (r_state == ACK),
        .i_last    (r_winner),
`endif
        .i_req     (req),
        .o_valid   (w_grant_valid),
        .o_idx     (w_grant_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the latched transaction registers are reset too, so an aborted
    // transaction leaves no stale data or mask behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_rdata  <= '0;
        end else begin
            if (r_state == IDLE && w_grant_valid) begin
                r_winner <= w_grant_idx;
                r_data   <= req_data[w_grant_idx*DATA_W +: DATA_W];
                r_mask   <= req_mask[w_grant_idx*DATA_W +: DATA_W];
            end
            if (r_state == READ) begin
                r_rdata <= pio_readdata;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        ack            = '0;
        busy           = 1'b1;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_grant_valid) begin
                    w_next = READ;
                end
            end
            READ: begin
                pio_chipselect = 1'b1;
                w_next         = WRITE;
            end
            WRITE: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_writedata  = (r_rdata & ~r_mask) | (r_data & r_mask);
                w_next         = ACK;
            end
            ACK: begin
                ack[r_winner] = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign pio_address = PIO_DATA_ADDR;

endmodule

// File: tb/tb_pio_rmw_arbiter.sv
// Directed self-checking bench for pio_rmw_arbiter with a single-register PIO slave model.
// Build with PIO_RMW_FIXED_PRI_EN to exercise the fixed-priority variant.
module tb_pio_rmw_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ*DATA_W-1:0] req_mask = '0;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [1:0]                pio_address;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [DATA_W-1:0]         pio_writedata;
    logic [DATA_W-1:0]         pio_readdata;

    logic [DATA_W-1:0] r_mem;
    logic              preset_en = 1'b0;
    logic [DATA_W-1:0] preset_val = '0;
    int                n_writes = 0;
    int                n_acks   = 0;
    int                cyc_cnt  = 0;
    int                n_checks = 0;
    int                n_fail   = 0;

    pio_rmw_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .ack            (ack),
        .busy           (busy),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata)
    );

    always #5 clk = ~clk;

    // PIO slave: one register, combinational read, written on a write strobe.
    assign pio_readdata = r_mem;

    always @(posedge clk) begin
        cyc_cnt++;
        if (ack != '0) n_acks++;
        if (preset_en) begin
            r_mem <= preset_val;
        end else if (pio_chipselect && !pio_write_n) begin
            r_mem <= pio_writedata;
            n_writes++;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [DATA_W-1:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick();
        preset_en  = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        req_data[i*DATA_W +: DATA_W] = d;
        req_mask[i*DATA_W +: DATA_W] = m;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},  64'(ack), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_cs"},   64'(pio_chipselect), 64'h0);
        check({tag, "_wrn"},  64'(pio_write_n), 64'h1);
        check({tag, "_addr"}, 64'(pio_address), 64'h0);
        check({tag, "_wdat"}, 64'(pio_writedata), 64'h0);
    endtask

    // Advances at least one cycle, then until an ack appears or the budget runs out.
    task automatic wait_ack(output logic [NUM_REQ-1:0] a, output int at_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < 20);
        if (ack == '0) check("ack_timeout", 64'h0, 64'h1);
        a      = ack;
        at_cyc = cyc_cnt;
    endtask

    initial begin
        logic [NUM_REQ-1:0] a;
        int                 t, t_prev, w0, k0;

        // Reset state
        reset_n = 1'b0;
        #2;
        check_reset_outputs("rst");
        preset(32'h0000_00FF);
        do_reset();

        // Single request: read 0xFF, write 0xAB0000FF, ack three cycles after grant edge
        set_req(1, 32'hAB00_0000, 32'hFF00_0000);
        req = 4'b0010;
        w0  = n_writes;
        tick();
        check("s_read_cs", 64'(pio_chipselect), 64'h1);
        check("s_read_wrn", 64'(pio_write_n), 64'h1);
        check("s_read_busy", 64'(busy), 64'h1);
        req = '0;
        tick();
        check("s_write_wrn", 64'(pio_write_n), 64'h0);
        check("s_write_data", 64'(pio_writedata), 64'hAB00_00FF);
        check("s_write_addr", 64'(pio_address), 64'h0);
        tick();
        check("s_ack", 64'(ack), 64'h2);
        check("s_ack_cs", 64'(pio_chipselect), 64'h0);
        tick();
        check("s_idle_ack", 64'(ack), 64'h0);
        check("s_idle_busy", 64'(busy), 64'h0);
        check("s_mem", 64'(r_mem), 64'hAB00_00FF);
        check("s_nwrites", 64'(n_writes - w0), 64'h1);

        // Latched values survive req drop and data change after grant
        preset(32'h1234_5678);
        set_req(2, 32'hCAFE_F00D, 32'h0000_FFFF);
        req = 4'b0100;
        tick();
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("m_write_data", 64'(pio_writedata), 64'h1234_F00D);
        tick();
        check("m_ack", 64'(ack), 64'h4);
        tick();
        check("m_mem", 64'(r_mem), 64'h1234_F00D);

        // All-zero mask still writes back the unchanged value
        preset(32'h5A5A_A5A5);
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0000);
        req = 4'b0010;
        w0  = n_writes;
        tick();
        req = '0;
        tick();
        check("z_write_wrn", 64'(pio_write_n), 64'h0);
        check("z_write_data", 64'(pio_writedata), 64'h5A5A_A5A5);
        tick();
        check("z_ack", 64'(ack), 64'h2);
        tick();
        check("z_nwrites", 64'(n_writes - w0), 64'h1);

        // Reset while in READ aborts: no write, no ack, reset outputs
        set_req(0, 32'h0000_0001, 32'h0000_0001);
        req = 4'b0001;
        tick();
        check("r_in_read", 64'(pio_chipselect), 64'h1);
        w0 = n_writes;
        k0 = n_acks;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("r_async");
        req = '0;
        repeat (3) tick();
        check("r_no_write", 64'(n_writes - w0), 64'h0);
        check("r_no_ack", 64'(n_acks - k0), 64'h0);
        reset_n = 1'b1;
        req = 4'b0001;
        t_prev = cyc_cnt;
        wait_ack(a, t);
        check("r_next_ack", 64'(a), 64'h1);
        check("r_next_lat", 64'(t - t_prev), 64'h3);
        req = '0;
        tick();

`ifdef PIO_RMW_FIXED_PRI_EN
        // Fixed priority: requester 0 always beats requester 2
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, t);
            check($sformatf("f_ack%0d", i), 64'(a), 64'h1);
        end
        req = '0;
        tick();
`else
        // Contention from reset: 0,1,2,3,0,... every 4 cycles
        preset(32'h0000_0000);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1111_1111 * (i + 1), 32'hFF << (8 * i));
        req = 4'hF;
        do_reset();
        t_prev = cyc_cnt;
        for (int i = 0; i < 8; i++) begin
            wait_ack(a, t);
            check($sformatf("c_ack%0d", i), 64'(a), 64'(1 << (i % NUM_REQ)));
            check($sformatf("c_gap%0d", i), 64'(t - t_prev), (i == 0) ? 64'h3 : 64'h4);
            t_prev = t;
        end
        req = '0;
        tick();
        tick();
        check("c_mem", 64'(r_mem), 64'h4433_2211);

        // Pointer wrap: after serving 2, pointer is 3; with 3 and 0 pending, 3 goes first
        do_reset();
        req = 4'b0100;
        wait_ack(a, t);
        check("w_ack2", 64'(a), 64'h4);
        req = 4'b1001;
        wait_ack(a, t);
        check("w_ack3", 64'(a), 64'h8);
        wait_ack(a, t);
        check("w_ack0", 64'(a), 64'h1);
        req = '0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
